// File: rtl/change_dispenser_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// change_dispenser_if
//   Request strobes in, actuator pulses and status out.
//   Revision: 1.0
// ----------------------------------------------------------------------------
interface change_dispenser_if #(
  parameter int TOTAL_W = 8
);
  logic [1:0]         coin_out;
  logic               soda;
  logic               eject_1;
  logic               eject_2;
  logic               soda_gate;
  logic               busy;
  logic               overflow;
  logic [TOTAL_W-1:0] dispensed_total;

  modport master (
    output coin_out, soda,
    input  eject_1, eject_2, soda_gate, busy, overflow, dispensed_total
  );

  modport slave (
    input  coin_out, soda,
    output eject_1, eject_2, soda_gate, busy, overflow, dispensed_total
  );
endinterface
`default_nettype wire

// File: rtl/change_dispenser.sv
`default_nettype none
// ----------------------------------------------------------------------------
// change_dispenser
//   Buffers coin/soda strobes and drives fixed-width actuator pulses.
//   Revision: 1.0
// ----------------------------------------------------------------------------
module change_dispenser #(
  parameter int PULSE_LEN  = 4,
  parameter int GAP_LEN    = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int TOTAL_W    = 8
) (
  input  wire logic          clk,
  input  wire logic          reset,
  change_dispenser_if.slave  bus
);

  localparam int c_PTR_W   = $clog2(FIFO_DEPTH);
  localparam int c_CNT_MAX = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;
  localparam logic [c_CNT_W-1:0] c_PULSE_INIT = c_CNT_W'(PULSE_LEN - 1);
  localparam logic [c_CNT_W-1:0] c_GAP_INIT   = c_CNT_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
  localparam logic [c_PTR_W:0]   c_FULL       = (c_PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FIRE = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t               r_state;
  logic [c_CNT_W-1:0]   r_cnt;
  logic [2:0]           r_job;
  logic [TOTAL_W-1:0]   r_total;
  logic                 r_overflow;

  logic [2:0]           r_mem [FIFO_DEPTH];
  logic [c_PTR_W-1:0]   r_wr_ptr;
  logic [c_PTR_W-1:0]   r_rd_ptr;
  logic [c_PTR_W:0]     r_count;

  logic [1:0]           w_coin;
  logic [2:0]           w_entry;
  logic                 w_push_req;
  logic                 w_pop;
  logic                 w_push;
  logic [1:0]           w_coin_val;
  logic [TOTAL_W+1:0]   w_sum;
  logic [TOTAL_W-1:0]   w_total_next;
  logic                 w_fire;

  // Reserved coin code 11 carries no coin, but a simultaneous soda still counts.
  assign w_coin     = (bus.coin_out == 2'b11) ? 2'b00 : bus.coin_out;
  assign w_entry    = {bus.soda, w_coin};
  assign w_push_req = |w_entry;
  assign w_pop      = (r_state == S_IDLE) && (r_count != '0);
  assign w_push     = w_push_req && ((r_count != c_FULL) || w_pop);

  assign w_coin_val   = (r_job[1:0] == 2'b01) ? 2'd1 :
                        (r_job[1:0] == 2'b10) ? 2'd2 : 2'd0;
  assign w_sum        = {2'b00, r_total} + {{TOTAL_W{1'b0}}, w_coin_val};
  assign w_total_next = (|w_sum[TOTAL_W+1:TOTAL_W]) ? {TOTAL_W{1'b1}} : w_sum[TOTAL_W-1:0];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_entry;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_push_req && !w_push) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_job   <= '0;
      r_total <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_job   <= r_mem[r_rd_ptr];
            r_cnt   <= c_PULSE_INIT;
            r_state <= S_FIRE;
          end
        end
        S_FIRE: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_total <= w_total_next;
            if (GAP_LEN == 0) begin
              r_state <= S_IDLE;
            end else begin
              r_cnt   <= c_GAP_INIT;
              r_state <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Actuators decode only from registers so they cannot glitch on input activity.
  assign w_fire              = (r_state == S_FIRE);
  assign bus.eject_1         = w_fire && (r_job[1:0] == 2'b01);
  assign bus.eject_2         = w_fire && (r_job[1:0] == 2'b10);
  assign bus.soda_gate       = w_fire && r_job[2];
  assign bus.busy            = (r_state != S_IDLE) || (r_count != '0);
  assign bus.overflow        = r_overflow;
  assign bus.dispensed_total = r_total;

endmodule
`default_nettype wire

// File: tb/tb_change_dispenser.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_change_dispenser
//   Directed stimulus with an expected-pulse queue checked by a pulse monitor.
//   Revision: 1.0
// ----------------------------------------------------------------------------
module tb_change_dispenser;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  change_dispenser_if #(.TOTAL_W(8)) bus_a ();
  change_dispenser_if #(.TOTAL_W(4)) bus_b ();

  change_dispenser #(.PULSE_LEN(4), .GAP_LEN(2), .FIFO_DEPTH(4), .TOTAL_W(8)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  change_dispenser #(.PULSE_LEN(4), .GAP_LEN(2), .FIFO_DEPTH(4), .TOTAL_W(4)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  wire [2:0] act_a = {bus_a.soda_gate, bus_a.eject_2, bus_a.eject_1};
  wire [2:0] act_b = {bus_b.soda_gate, bus_b.eject_2, bus_b.eject_1};

  typedef struct {
    int         id;
    logic [2:0] act;
    int         start;
    int         total;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Pulse monitor: one tracker per DUT, pops an expectation when a pulse ends.
  bit         in_p [2];
  logic [2:0] vec  [2];
  int         st   [2];
  int         len  [2];
  logic [2:0] m_a;
  int         m_tot;
  exp_t       m_e;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      m_a   = (k == 0) ? act_a : act_b;
      m_tot = (k == 0) ? int'(bus_a.dispensed_total) : int'(bus_b.dispensed_total);
      if (!reset) begin
        in_p[k] = 1'b0;
      end else if (!in_p[k]) begin
        if (m_a != 3'b000) begin
          in_p[k] = 1'b1;
          st[k]   = cyc;
          vec[k]  = m_a;
          len[k]  = 1;
        end
      end else if (m_a == vec[k]) begin
        len[k]++;
      end else begin
        in_p[k] = 1'b0;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_pulse: dut %0d act %b started cycle %0d, required none", k, vec[k], st[k]);
        end else begin
          m_e = exp_q.pop_front();
          chk("pulse_dut",   k,            m_e.id);
          chk("pulse_act",   int'(vec[k]), int'(m_e.act));
          chk("pulse_start", st[k],        m_e.start);
          chk("pulse_len",   len[k],       4);
          chk("total_after", m_tot,        m_e.total);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input logic [1:0] c, input logic s);
    if (k == 0) begin
      bus_a.coin_out = c;
      bus_a.soda     = s;
    end else begin
      bus_b.coin_out = c;
      bus_b.soda     = s;
    end
  endtask

  task automatic expect_pulse(input int id, input logic [2:0] act, input int start, input int total);
    exp_t e;
    e.id    = id;
    e.act   = act;
    e.start = start;
    e.total = total;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL %s_drain: got %0d pulses outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (4) tick();
  endtask

  task automatic do_reset();
    drive(0, 2'b00, 1'b0);
    drive(1, 2'b00, 1'b0);
    reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int b;
    drive(0, 2'b00, 1'b0);
    drive(1, 2'b00, 1'b0);
    repeat (2) tick();

    // Reset state
    chk("rst_act_a",      int'(act_a), 0);
    chk("rst_busy_a",     int'(bus_a.busy), 0);
    chk("rst_overflow_a", int'(bus_a.overflow), 0);
    chk("rst_total_a",    int'(bus_a.dispensed_total), 0);
    chk("rst_act_b",      int'(act_b), 0);
    chk("rst_total_b",    int'(bus_b.dispensed_total), 0);
    reset = 1'b1;
    tick();

    // 1: single two-unit coin
    b = cyc;
    drive(0, 2'b10, 1'b0);
    expect_pulse(0, 3'b010, b + 2, 2);
    tick();
    drive(0, 2'b00, 1'b0);
    repeat (6) tick();
    chk("t1_busy_c7", int'(bus_a.busy), 1);
    tick();
    chk("t1_busy_c8", int'(bus_a.busy), 0);
    chk("t1_total",   int'(bus_a.dispensed_total), 2);
    drain("t1");

    // 2: back-to-back coin 10, coin 01, soda
    do_reset();
    b = cyc;
    drive(0, 2'b10, 1'b0);
    expect_pulse(0, 3'b010, b + 2, 2);
    tick();
    drive(0, 2'b01, 1'b0);
    expect_pulse(0, 3'b001, b + 9, 3);
    tick();
    drive(0, 2'b00, 1'b1);
    expect_pulse(0, 3'b100, b + 16, 3);
    tick();
    drive(0, 2'b00, 1'b0);
    drain("t2");
    chk("t2_total",    int'(bus_a.dispensed_total), 3);
    chk("t2_overflow", int'(bus_a.overflow), 0);
    chk("t2_busy",     int'(bus_a.busy), 0);

    // 3: six consecutive strobes into a 4-deep FIFO
    do_reset();
    b = cyc;
    for (int i = 0; i < 6; i++) begin
      drive(0, 2'b01, 1'b0);
      if (i < 5) expect_pulse(0, 3'b001, b + 2 + 7 * i, i + 1);
      if (i == 5) chk("t3_overflow_c5", int'(bus_a.overflow), 0);
      tick();
    end
    drive(0, 2'b00, 1'b0);
    chk("t3_overflow_c6", int'(bus_a.overflow), 1);
    drain("t3");
    chk("t3_total",          int'(bus_a.dispensed_total), 5);
    chk("t3_overflow_stick", int'(bus_a.overflow), 1);

    // 4: reserved coin code alone is ignored; with soda only the gate fires
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(0, 2'b11, 1'b0);
      tick();
      chk("t4_busy", int'(bus_a.busy), 0);
    end
    drive(0, 2'b00, 1'b0);
    tick();
    chk("t4_busy_after", int'(bus_a.busy), 0);
    b = cyc;
    drive(0, 2'b11, 1'b1);
    expect_pulse(0, 3'b100, b + 2, 0);
    tick();
    drive(0, 2'b00, 1'b0);
    drain("t4");
    chk("t4_total", int'(bus_a.dispensed_total), 0);

    // 5: reset in the middle of a pulse with two jobs queued
    do_reset();
    b = cyc;
    drive(0, 2'b01, 1'b0);
    expect_pulse(0, 3'b001, b + 2, 1);
    tick();
    drive(0, 2'b00, 1'b0);
    drain("t5_pre");
    chk("t5_total_pre", int'(bus_a.dispensed_total), 1);
    drive(0, 2'b10, 1'b0);
    tick();
    drive(0, 2'b01, 1'b0);
    tick();
    drive(0, 2'b10, 1'b0);
    tick();
    drive(0, 2'b00, 1'b0);
    tick();
    chk("t5_eject2_before", int'(bus_a.eject_2), 1);
    #2;
    reset = 1'b0;
    #1;
    chk("t5_act_in_reset",      int'(act_a), 0);
    chk("t5_total_in_reset",    int'(bus_a.dispensed_total), 0);
    chk("t5_overflow_in_reset", int'(bus_a.overflow), 0);
    chk("t5_busy_in_reset",     int'(bus_a.busy), 0);
    repeat (2) tick();
    reset = 1'b1;
    repeat (40) tick();
    chk("t5_busy_after",  int'(bus_a.busy), 0);
    chk("t5_total_after", int'(bus_a.dispensed_total), 0);

    // 6: saturation of a 4-bit total
    do_reset();
    for (int i = 0; i < 9; i++) begin
      b = cyc;
      drive(1, 2'b10, 1'b0);
      expect_pulse(1, 3'b010, b + 2, (2 * (i + 1) > 15) ? 15 : 2 * (i + 1));
      tick();
      drive(1, 2'b00, 1'b0);
      repeat (7) tick();
    end
    drain("t6");
    chk("t6_total_sat", int'(bus_b.dispensed_total), 15);
    chk("t6_busy",      int'(bus_b.busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
